// File: rtl/viterbi_pkg.sv
// Shared Viterbi definitions: trellis sizing helpers, state type, predecessor
// function (also used by the ACS unit) and the traceback FSM encoding.
package viterbi_pkg;

  localparam int unsigned MAX_SW = 16;

  typedef logic [MAX_SW-1:0] vit_state_t;

  typedef enum logic [1:0] {
    TB_IDLE,
    TB_TRACE,
    TB_DONE
  } tb_fsm_e;

  function automatic int unsigned vit_ns(input int unsigned k);
    return 32'd1 << (k - 1);
  endfunction

  function automatic int unsigned vit_sw(input int unsigned k);
    return k - 1;
  endfunction

  // Predecessor of state s = {dec, s[SW-1:1]}; bits above sw are zero.
  function automatic vit_state_t vit_pred(input vit_state_t s, input logic dec,
                                          input int unsigned sw);
    vit_state_t p;
    p = s >> 1;
    p[sw-1] = dec;
    return p;
  endfunction

endpackage

// File: rtl/viterbi_traceback_mem_if.sv
// Decision-column input and decoded-frame output handshakes.
interface viterbi_traceback_mem_if #(
  parameter int unsigned NS = 4,
  parameter int unsigned SW = 2,
  parameter int unsigned D  = 8
);
  logic          dec_valid;
  logic [NS-1:0] dec_bits;
  logic [SW-1:0] best_state;
  logic          in_ready;
  logic          out_valid;
  logic [D-1:0]  out_data;
  logic          out_ready;

  modport master (
    output dec_valid, dec_bits, best_state, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  dec_valid, dec_bits, best_state, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/vit_survivor_ram.sv
// Two ping-pong banks of D decision columns, NS bits each.
// Single write port, combinational column read. Contents are not reset.
module vit_survivor_ram #(
  parameter int unsigned NS = 4,
  parameter int unsigned D  = 8,
  localparam int unsigned CW = (D > 1) ? $clog2(D) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic          wr_bank,
  input  logic [CW-1:0] wr_col,
  input  logic [NS-1:0] wr_data,
  input  logic          rd_bank,
  input  logic [CW-1:0] rd_col,
  output logic [NS-1:0] rd_data
);

  logic [NS-1:0] mem [2][D];

  // Store an accepted decision column.
  always_ff @(posedge clk) begin
    if (we) mem[wr_bank][wr_col] <= wr_data;
  end

  assign rd_data = mem[rd_bank][rd_col];

endmodule

// File: rtl/viterbi_traceback_mem.sv
// Survivor-path memory and traceback: buffers decision columns in two banks,
// traces each full frame back from its start state and emits the decoded word.
module viterbi_traceback_mem
  import viterbi_pkg::*;
#(
  parameter int unsigned K        = 3,
  parameter int unsigned TB_DEPTH = 8,
  parameter bit          TERM     = 1'b0
) (
  input logic                    clk,
  input logic                    rst,
  viterbi_traceback_mem_if.slave bus
);

  localparam int unsigned NS = vit_ns(K);
  localparam int unsigned SW = vit_sw(K);
  localparam int unsigned D  = TB_DEPTH;
  localparam int unsigned CW = (D > 1) ? $clog2(D) : 1;

  logic          wr_bank_q, wr_bank_d;
  logic [CW-1:0] wr_col_q, wr_col_d;
  logic [1:0]    bank_full_q, bank_full_d;
  logic [SW-1:0] start_q [2];
  logic [SW-1:0] start_d [2];
  logic          rd_bank_q, rd_bank_d;
  tb_fsm_e       fsm_q, fsm_d;
  logic [SW-1:0] s_q, s_d;
  logic [CW-1:0] col_q, col_d;
  logic [D-1:0]  tb_bits_q, tb_bits_d;
  logic          out_valid_q, out_valid_d;
  logic [D-1:0]  out_data_q, out_data_d;

  logic          in_ready;
  logic          wr_en;
  logic          wr_last;
  logic [NS-1:0] rd_col;

  assign in_ready      = !bank_full_q[wr_bank_q];
  assign wr_en         = bus.dec_valid && in_ready;
  assign wr_last       = (wr_col_q == CW'(D - 1));
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  vit_survivor_ram #(
    .NS(NS),
    .D (D)
  ) u_ram (
    .clk    (clk),
    .we     (wr_en),
    .wr_bank(wr_bank_q),
    .wr_col (wr_col_q),
    .wr_data(bus.dec_bits),
    .rd_bank(rd_bank_q),
    .rd_col (col_q),
    .rd_data(rd_col)
  );

  // Next state for the write pointer, bank flags and traceback FSM.
  always_comb begin
    wr_bank_d   = wr_bank_q;
    wr_col_d    = wr_col_q;
    bank_full_d = bank_full_q;
    start_d     = start_q;
    rd_bank_d   = rd_bank_q;
    fsm_d       = fsm_q;
    s_d         = s_q;
    col_d       = col_q;
    tb_bits_d   = tb_bits_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_data_d  = out_data_q;

    if (wr_en) begin
      if (wr_last) begin
        bank_full_d[wr_bank_q] = 1'b1;
        start_d[wr_bank_q]     = TERM ? '0 : bus.best_state;
        wr_bank_d              = !wr_bank_q;
        wr_col_d               = '0;
      end else begin
        wr_col_d = wr_col_q + 1'b1;
      end
    end

    case (fsm_q)
      TB_IDLE: begin
        if (bank_full_q[rd_bank_q]) begin
          fsm_d = TB_TRACE;
          s_d   = start_q[rd_bank_q];
          col_d = CW'(D - 1);
        end
      end
      TB_TRACE: begin
        tb_bits_d[col_q] = s_q[0];
        s_d   = SW'(vit_pred(vit_state_t'(s_q), rd_col[s_q], SW));
        col_d = col_q - 1'b1;
        if (col_q == '0) begin
          bank_full_d[rd_bank_q] = 1'b0;
          rd_bank_d              = !rd_bank_q;
          fsm_d                  = TB_DONE;
        end
      end
      TB_DONE: begin
        if (!out_valid_q || bus.out_ready) begin
          out_data_d  = tb_bits_q;
          out_valid_d = 1'b1;
          fsm_d       = TB_IDLE;
        end
      end
      default: fsm_d = TB_IDLE;
    endcase
  end

  // State registers; reset discards every buffered and in-flight frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank_q   <= 1'b0;
      wr_col_q    <= '0;
      bank_full_q <= '0;
      start_q[0]  <= '0;
      start_q[1]  <= '0;
      rd_bank_q   <= 1'b0;
      fsm_q       <= TB_IDLE;
      s_q         <= '0;
      col_q       <= '0;
      tb_bits_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      wr_col_q    <= wr_col_d;
      bank_full_q <= bank_full_d;
      start_q     <= start_d;
      rd_bank_q   <= rd_bank_d;
      fsm_q       <= fsm_d;
      s_q         <= s_d;
      col_q       <= col_d;
      tb_bits_q   <= tb_bits_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_viterbi_traceback_mem.sv
// Scoreboard bench: three instances (K=3/TERM=0, K=3/TERM=1, K=5/D=32).
// Frames are built from a known input bit sequence; the expected word is that
// sequence, queued when the frame is issued and popped by per-instance monitors.
module tb_viterbi_traceback_mem;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  viterbi_traceback_mem_if #(.NS(4),  .SW(2), .D(8))  a_if ();
  viterbi_traceback_mem_if #(.NS(4),  .SW(2), .D(8))  b_if ();
  viterbi_traceback_mem_if #(.NS(16), .SW(4), .D(32)) c_if ();

  viterbi_traceback_mem #(.K(3), .TB_DEPTH(8), .TERM(1'b0)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave));
  viterbi_traceback_mem #(.K(3), .TB_DEPTH(8), .TERM(1'b1)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.slave));
  viterbi_traceback_mem #(.K(5), .TB_DEPTH(32), .TERM(1'b0)) dut_c (
    .clk(clk), .rst(rst), .bus(c_if.slave));

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  logic [31:0] exp_c[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitors: a handshake is visible at the negedge before the accepting edge.
  always @(negedge clk) begin
    if (rst && a_if.out_valid && a_if.out_ready) begin
      if (exp_a.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL a_unexpected: got %h expected nothing", a_if.out_data);
      end else check("a_frame", 32'(a_if.out_data), exp_a.pop_front());
    end
    if (rst && b_if.out_valid && b_if.out_ready) begin
      if (exp_b.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL b_unexpected: got %h expected nothing", b_if.out_data);
      end else check("b_frame", 32'(b_if.out_data), exp_b.pop_front());
    end
    if (rst && c_if.out_valid && c_if.out_ready) begin
      if (exp_c.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL c_unexpected: got %h expected nothing", c_if.out_data);
      end else check("c_frame", c_if.out_data, exp_c.pop_front());
    end
  end

  task automatic set_in(input int unsigned dut, input logic v, input logic [15:0] dec,
                        input logic [3:0] best);
    case (dut)
      0: begin a_if.dec_valid = v; a_if.dec_bits = dec[3:0]; a_if.best_state = best[1:0]; end
      1: begin b_if.dec_valid = v; b_if.dec_bits = dec[3:0]; b_if.best_state = best[1:0]; end
      default: begin c_if.dec_valid = v; c_if.dec_bits = dec; c_if.best_state = best; end
    endcase
  endtask

  function automatic logic get_in_ready(input int unsigned dut);
    case (dut)
      0: return a_if.in_ready;
      1: return b_if.in_ready;
      default: return c_if.in_ready;
    endcase
  endfunction

  task automatic idle(input int unsigned dut);
    @(negedge clk);
    set_in(dut, 1'b0, '0, '0);
  endtask

  // Encode u (bit t = symbol t) from state 0; off-path decision bits are random
  // unless zero_cols. Returns just after the edge that accepts the last column.
  task automatic send_frame(input int unsigned dut, input logic [31:0] u, input bit zero_cols,
                            input bit force_best, input logic [3:0] best_val,
                            input bit push, input logic [31:0] expw);
    int unsigned d;
    int unsigned sw;
    int unsigned waitc;
    logic [3:0]  mask;
    logic [3:0]  s;
    logic [3:0]  prev;
    logic [15:0] col;
    d    = (dut == 2) ? 32 : 8;
    sw   = (dut == 2) ? 4 : 2;
    mask = (dut == 2) ? 4'hF : 4'h3;
    s    = '0;
    if (push) begin
      case (dut)
        0: exp_a.push_back(expw);
        1: exp_b.push_back(expw);
        default: exp_c.push_back(expw);
      endcase
    end
    for (int unsigned t = 0; t < d; t++) begin
      prev = s;
      s    = ((s << 1) | {3'b000, u[t]}) & mask;
      col  = zero_cols ? 16'h0 : 16'($urandom);
      col[s] = prev[sw-1];
      @(negedge clk);
      set_in(dut, 1'b1, col, force_best ? best_val : s);
      waitc = 0;
      while (!get_in_ready(dut) && waitc < 300) begin
        @(negedge clk);
        waitc++;
      end
      if (waitc >= 300) begin
        n_vec++; n_bad++;
        $display("FAIL in_ready_timeout: got 0 expected 1 (dut %0d)", dut);
        break;
      end
      @(posedge clk);
    end
  endtask

  task automatic set_ready(input int unsigned dut, input logic v);
    @(posedge clk);
    #1;
    case (dut)
      0: a_if.out_ready = v;
      1: b_if.out_ready = v;
      default: c_if.out_ready = v;
    endcase
  endtask

  task automatic drain();
    int unsigned waitc;
    waitc = 0;
    while ((exp_a.size() + exp_b.size() + exp_c.size()) > 0 && waitc < 5000) begin
      @(posedge clk);
      waitc++;
    end
    if (waitc >= 5000) begin
      n_vec++; n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               exp_a.size() + exp_b.size() + exp_c.size());
      exp_a.delete(); exp_b.delete(); exp_c.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  logic [31:0] stall_words [4] = '{32'hA5, 32'h3C, 32'hF0, 32'h69};

  initial begin
    int unsigned n;
    logic [31:0] u;
    set_in(0, 1'b0, '0, '0);
    set_in(1, 1'b0, '0, '0);
    set_in(2, 1'b0, '0, '0);
    a_if.out_ready = 1'b1;
    b_if.out_ready = 1'b1;
    c_if.out_ready = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(a_if.out_valid), 32'd0);
    check("rst_out_data",  32'(a_if.out_data),  32'd0);
    check("rst_in_ready",  32'(a_if.in_ready),  32'd1);
    check("rst_c_in_ready", 32'(c_if.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // All-zero frame, start state 0: output 8'h00 on the 10th edge.
    send_frame(0, 32'h00, 1'b1, 1'b1, 4'h0, 1'b1, 32'h00);
    fork idle(0); join_none
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      #1;
      if (a_if.out_valid) break;
    end
    check("latency_edges", n, 32'd10);
    drain();

    // Input 1,0,1,1,0,0,1,0 ends in state 2'b10 -> 8'h4D.
    send_frame(0, 32'h4D, 1'b0, 1'b1, 4'h2, 1'b1, 32'h4D);
    idle(0);
    drain();

    // Zero-tailed frames: TERM=1 ignores best_state=3; TERM=0 from state 0 agrees.
    send_frame(1, 32'h35, 1'b0, 1'b1, 4'h3, 1'b1, 32'h35);
    send_frame(1, 32'h1B, 1'b0, 1'b1, 4'h3, 1'b1, 32'h1B);
    idle(1);
    send_frame(0, 32'h35, 1'b0, 1'b1, 4'h0, 1'b1, 32'h35);
    idle(0);
    drain();

    // Back-pressure: output reg + DONE + two banks hold four frames.
    set_ready(0, 1'b0);
    for (int unsigned i = 0; i < 4; i++)
      send_frame(0, stall_words[i], 1'b0, 1'b0, 4'h0, 1'b1, stall_words[i]);
    idle(0);
    repeat (40) @(posedge clk);
    #1;
    check("stall_in_ready",  32'(a_if.in_ready),  32'd0);
    check("stall_out_valid", 32'(a_if.out_valid), 32'd1);
    check("stall_out_data",  32'(a_if.out_data),  32'hA5);
    set_ready(0, 1'b1);
    drain();
    #1;
    check("release_in_ready", 32'(a_if.in_ready), 32'd1);

    // Reset during TRACE discards the frame; the next frame decodes normally.
    send_frame(0, 32'hC3, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0);
    fork idle(0); join_none
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(a_if.out_valid), 32'd0);
    check("midrst_in_ready",  32'(a_if.in_ready),  32'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_output", 32'(a_if.out_valid), 32'd0);
    send_frame(0, 32'h5A, 1'b0, 1'b0, 4'h0, 1'b1, 32'h5A);
    idle(0);
    drain();

    // K=5, D=32: 100 back-to-back random frames.
    for (int unsigned i = 0; i < 100; i++) begin
      u = $urandom;
      send_frame(2, u, 1'b0, 1'b0, 4'h0, 1'b1, u);
    end
    idle(2);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
